// File: rtl/delay_arbiter_pkg.sv
// Shared constants for the delay arbiter: FSM state encodings and default sizes.
package delay_arbiter_pkg;

    localparam int DEF_NREQ = 4;
    localparam int DEF_CW   = 16;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

endpackage

// File: rtl/delay_core.sv
// Loadable down-counter for the shared delay; saturates at zero so it never wraps.
module delay_core
    import delay_arbiter_pkg::*;
#(
    parameter int CW = DEF_CW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    input  logic          clr,
    output logic [CW-1:0] remain,
    output logic          one
);

    // Clear wins over load, load wins over decrement.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            remain <= '0;
        end else if (load) begin
            remain <= load_val;
        end else if (dec && (remain != '0)) begin
            remain <= remain - 1'b1;
        end
    end

    assign one = (remain == CW'(1));

endmodule

// File: rtl/delay_arbiter.sv
// Round-robin owner of one shared delay counter; grants, counts in tick units, pulses done.
module delay_arbiter
    import delay_arbiter_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int CW   = DEF_CW
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*CW-1:0] len,
    output logic [NREQ-1:0]    grant,
    output logic [NREQ-1:0]    done,
    output logic               busy,
    output logic [CW-1:0]      remain
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [1:0]    state;
    logic [IW-1:0] idx;
    logic [IW-1:0] last;
    logic [IW:0]   pick;
    logic [CW-1:0] len_sel;
    logic          cnt_load;
    logic          cnt_dec;
    logic          cnt_clr;
    logic          cnt_one;
    logic [NREQ-1:0] owner;

    // Returns {found, index}: first set request searching upward from last+1, wrapping.
    function automatic logic [IW:0] pick_next(input logic [NREQ-1:0] r, input logic [IW-1:0] l);
        logic          found;
        logic [IW-1:0] sel;
        found = 1'b0;
        sel   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            int i;
            i = (int'(l) + k) % NREQ;
            if (r[i] && !found) begin
                found = 1'b1;
                sel   = IW'(i);
            end
        end
        return {found, sel};
    endfunction

    assign pick    = pick_next(req, last);
    assign len_sel = len[int'(idx)*CW +: CW];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
            last  <= IW'(NREQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (pick[IW]) begin
                        idx   <= pick[IW-1:0];
                        state <= LOAD;
                    end
                end
                LOAD: state <= (len_sel == '0) ? DONE : RUN;
                RUN: begin
                    // A dropped request cancels, even on the cycle the count would finish.
                    if (!req[idx]) begin
                        last  <= idx;
                        state <= IDLE;
                    end else if (tick && cnt_one) begin
                        state <= DONE;
                    end
                end
                default: begin
                    last  <= idx;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign cnt_load = (state == LOAD);
    assign cnt_dec  = (state == RUN) && req[idx] && tick;
    assign cnt_clr  = (state == IDLE) || ((state == RUN) && !req[idx]);

    delay_core #(.CW(CW)) u_core (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (len_sel),
        .dec      (cnt_dec),
        .clr      (cnt_clr),
        .remain   (remain),
        .one      (cnt_one)
    );

    assign owner = {{(NREQ-1){1'b0}}, 1'b1} << idx;
    assign busy  = (state != IDLE);
    assign grant = busy ? owner : '0;
    assign done  = (state == DONE) ? owner : '0;

endmodule

// File: tb/tb_delay_arbiter.sv
// Directed bench for delay_arbiter: done pulses are scoreboarded, other outputs checked inline.
module tb_delay_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        tick;
    logic [3:0]  req;
    logic [63:0] len;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic        busy;
    logic [15:0] remain;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int c;

    typedef struct {
        logic [3:0] mask;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];

    delay_arbiter #(.NREQ(4), .CW(16)) dut (
        .clk    (clk),
        .reset  (reset),
        .tick   (tick),
        .req    (req),
        .len    (len),
        .grant  (grant),
        .done   (done),
        .busy   (busy),
        .remain (remain)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every done pulse must match the oldest expected pulse, mask and cycle.
    always @(negedge clk) begin
        if (done !== 4'b0000) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("[TB] FAIL unexpectedDone cyc=%0d got=%b expected none", cyc, done);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (done !== e.mask || cyc != e.cyc) begin
                    failures++;
                    $display("[TB] FAIL doneEvent got mask=%b cyc=%0d expected mask=%b cyc=%0d",
                             done, cyc, e.mask, e.cyc);
                end
            end
        end
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [63:0] mk_len(input logic [15:0] l0, l1, l2, l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic applyStimulus(input logic [3:0] r, input logic [63:0] l);
        req = r;
        len = l;
    endtask

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, actual, expected);
        end
    endtask

    task automatic expectDone(input logic [3:0] mask, input int at);
        exp_t e;
        e.mask = mask;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    task automatic stepTo(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic doReset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        tick  = 1'b1;
        applyStimulus(4'b0000, 64'd0);
        repeat (3) @(negedge clk);
        checkOutput("resetGrant", grant, 0);
        checkOutput("resetBusy", busy, 0);
        checkOutput("resetRemain", remain, 0);
        checkOutput("resetDone", done, 0);

        // Single request straight out of reset, len=5.
        reset = 1'b0;
        applyStimulus(4'b0001, mk_len(16'd5, 16'd0, 16'd0, 16'd0));
        c = cyc;
        expectDone(4'b0001, c + 7);
        stepTo(c + 1); checkOutput("singleGrant", grant, 4'b0001);
        stepTo(c + 2); checkOutput("singleRemain", remain, 5);
        stepTo(c + 7); checkOutput("singleBusyAtDone", busy, 1);
        applyStimulus(4'b0000, len);
        stepTo(c + 8); checkOutput("singleBusyAfter", busy, 0);

        // Round-robin contention 0,1,3,0 with a one-cycle idle gap between owners.
        doReset();
        applyStimulus(4'b1011, mk_len(16'd1, 16'd1, 16'd1, 16'd1));
        c = cyc;
        expectDone(4'b0001, c + 3);
        expectDone(4'b0010, c + 7);
        expectDone(4'b1000, c + 11);
        expectDone(4'b0001, c + 15);
        stepTo(c + 1);  checkOutput("rrGrant0", grant, 4'b0001);
        stepTo(c + 4);  checkOutput("rrIdleGap", grant, 4'b0000);
        stepTo(c + 5);  checkOutput("rrGrant1", grant, 4'b0010);
        stepTo(c + 9);  checkOutput("rrGrant3", grant, 4'b1000);
        stepTo(c + 13); checkOutput("rrGrant0b", grant, 4'b0001);
        stepTo(c + 15);
        applyStimulus(4'b0000, len);

        // Zero length: done two cycles after the request is sampled.
        stepTo(c + 17);
        applyStimulus(4'b0100, mk_len(16'd0, 16'd0, 16'd0, 16'd0));
        c = cyc;
        expectDone(4'b0100, c + 2);
        stepTo(c + 1); checkOutput("zeroGrant", grant, 4'b0100);
        stepTo(c + 2); checkOutput("zeroRemain", remain, 0);
        applyStimulus(4'b0000, len);

        // Maximum length counts all the way down without wrapping.
        stepTo(c + 4);
        applyStimulus(4'b0001, mk_len(16'hFFFF, 16'd0, 16'd0, 16'd0));
        c = cyc;
        expectDone(4'b0001, c + 65537);
        stepTo(c + 2);     checkOutput("maxRemainStart", remain, 16'hFFFF);
        stepTo(c + 65536); checkOutput("maxRemainOne", remain, 1);
        stepTo(c + 65537); checkOutput("maxRemainDone", remain, 0);
        applyStimulus(4'b0000, len);

        // Tick gating: pattern 1,0,0,1,1 in RUN stretches the delay by two cycles.
        stepTo(c + 65539);
        applyStimulus(4'b0010, mk_len(16'd0, 16'd3, 16'd0, 16'd0));
        c = cyc;
        expectDone(4'b0010, c + 7);
        stepTo(c + 2); tick = 1'b1;
        stepTo(c + 3); tick = 1'b0;
        stepTo(c + 4); tick = 1'b0; checkOutput("tickHold1", remain, 2);
        stepTo(c + 5); tick = 1'b1; checkOutput("tickHold2", remain, 2);
        stepTo(c + 6); tick = 1'b1; checkOutput("tickRemainOne", remain, 1);
        stepTo(c + 7);
        applyStimulus(4'b0000, len);

        // Cancel on the remain==1 cycle: no done, next owner is requester 3.
        stepTo(c + 9);
        applyStimulus(4'b0100, mk_len(16'd0, 16'd0, 16'd2, 16'd1));
        c = cyc;
        stepTo(c + 1); checkOutput("cancelGrant", grant, 4'b0100);
        stepTo(c + 3); checkOutput("cancelRemainOne", remain, 1);
        applyStimulus(4'b0000, len);
        stepTo(c + 4); checkOutput("cancelBusy", busy, 0);
        checkOutput("cancelGrantCleared", grant, 0);
        applyStimulus(4'b1100, len);
        expectDone(4'b1000, c + 7);
        stepTo(c + 5); checkOutput("cancelNextGrant", grant, 4'b1000);
        stepTo(c + 7);
        applyStimulus(4'b0000, len);

        // Reset mid-RUN drops the delay; afterwards requester 0 beats requester 1.
        stepTo(c + 9);
        applyStimulus(4'b0001, mk_len(16'd10, 16'd1, 16'd0, 16'd0));
        c = cyc;
        stepTo(c + 8); checkOutput("midRunRemain", remain, 4);
        reset = 1'b1;
        applyStimulus(4'b0011, mk_len(16'd1, 16'd1, 16'd0, 16'd0));
        stepTo(c + 9);
        checkOutput("midResetGrant", grant, 0);
        checkOutput("midResetBusy", busy, 0);
        checkOutput("midResetRemain", remain, 0);
        reset = 1'b0;
        expectDone(4'b0001, c + 12);
        stepTo(c + 10); checkOutput("postResetGrant", grant, 4'b0001);
        stepTo(c + 12);
        applyStimulus(4'b0000, len);

        repeat (4) @(negedge clk);
        checkOutput("scoreboardEmpty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/delay_arbiter.md
# delay_arbiter

Shares one programmable delay counter among NREQ requesters. Each requester raises a request with its own delay length. The block grants the counter to one requester at a time in round-robin order, counts the delay in `tick` units, and returns a one-cycle completion pulse. It sits between the user-project logic blocks and the shared timing resource, and replaces per-block free-running counters.

## Interface

Parameters:
- NREQ, 4, number of requesters (2..8)
- CW, 16, delay counter width in bits

Ports:
- clk  in  1  clock; all logic on posedge
- reset  in  1  synchronous, active-high; clock clk
- tick  in  1  count enable; counter decrements only when tick=1 (tie to 1 for cycle-accurate delays)
- req  in  NREQ  level request per requester; must be held until done or cancel
- len  in  NREQ*CW  delay length; requester i uses len[i*CW +: CW]
- grant  out  NREQ  one-hot owner of the counter; all-zero when idle
- done  out  NREQ  one-cycle completion pulse to the granted requester
- busy  out  1  counter owned (state != IDLE)
- remain  out  CW  current remaining count; 0 when idle

## Operation

- FSM states: IDLE, LOAD, RUN, DONE. All outputs are registered or decoded from registered state only.
- IDLE:
  - If any req bit is set, select the first set bit searching upward from (last+1) mod NREQ, wrapping.
  - Latch the index in idx, set grant[idx], and go to LOAD.
  - If no req bit is set, stay in IDLE.
- LOAD:
  - remain <= len[idx] (sampled only in this cycle).
  - If len[idx]==0, go to DONE. Otherwise go to RUN.
- RUN:
  - If req[idx]==0, this is a cancel. Clear grant, set last<=idx, go to IDLE. No done pulse is issued; cancel has priority over completion in the same cycle.
  - Else if tick==1 and remain==1: remain<=0, go to DONE.
  - Else if tick==1: remain<=remain-1.
  - tick==0 holds remain.
- DONE:
  - done[idx]=1 for exactly this cycle.
  - Go to IDLE with grant cleared and last<=idx.
  - There is no cancel check in DONE.
- Round-robin: last resets to NREQ-1, so after reset req[0] has highest priority. A requester that holds req after its done pulse loses priority to every other pending requester.
- Changes to len while the counter is owned are ignored.
- Reset mid-operation: go to IDLE immediately. No done pulse is issued and the current delay is lost.

## Timing

- Reset values: grant=0, done=0, busy=0, remain=0, state=IDLE, last=NREQ-1.
- req sampled in IDLE at cycle t, then:
  - grant visible at t+1 (LOAD).
  - remain=L at t+2 (RUN).
- With tick held at 1 and L>=1, done pulses at t+2+L.
- With L=0, done pulses at t+2.
- With L=2^CW-1 (maximum), done pulses at t+1+2^CW. No wrap occurs, because remain never decrements below 0.
- busy is high from t+1 through the done cycle inclusive.
- Minimum spacing between consecutive grants is 1 IDLE cycle, so grant drops for at least one cycle between owners.
- tick low cycles stretch RUN one-for-one.

## Structure

- Package delay_arbiter_pkg holds:
  - the state enum (IDLE=2'd0, LOAD=2'd1, RUN=2'd2, DONE=2'd3);
  - the default CW and NREQ localparams.
- Sub-module delay_core holds the CW-bit loadable down-counter.
  - Ports: clk, reset, load, load_val, dec, clr, remain, one (remain==1).
- The top level contains the FSM, the round-robin picker (a function over req and last) and the output decode.

## Test plan

- Single request, reset release: req=4'b0001, len0=5, tick=1 from t=0 -> grant=4'b0001 at t=1, done[0] at t=7, busy low at t=8.
- Round-robin contention: req=4'b1011 held, all len=1 -> grants in order 0,1,3,0 with done[0], done[1], done[3], done[0]. Consecutive grants are separated by one idle cycle.
- Zero and maximum length:
  - len=0 -> done at t+2.
  - len=16'hFFFF with tick=1 -> done at t+65537, remain steps 16'hFFFF to 1 with no wrap.
- Tick gating: len=3, tick pattern 1,0,0,1,1 in RUN -> done two cycles later than with tick=1; remain holds during tick=0.
- Cancel: req[2] dropped at the same RUN cycle where remain==1 -> no done[2], back in IDLE, and next grant goes to req[3] when req=4'b1100.
- Reset mid-RUN: assert reset with remain=4 -> next cycle grant=0, busy=0, remain=0, and no done pulse. After release, req[0] wins over req[1].
